dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Shares the single 32-bit, word-wide DLA DRAM port between N burst requesters: ifmap loader, filter loader, bias loader and opsum writer.
- Each requester asks for a burst of 32-bit words at a byte base address, read or write.
- Grants rotate round-robin, and a granted burst owns the port until its last beat.
- Sits inside Top between the loaders/writer and the dram_we/dram_addr/dram_w_data/dram_r_data pins.

Parameters:
- N_REQ, 4, number of requesters (0 = ifmap, 1 = filter, 2 = bias, 3 = opsum).
- ADDR_WIDTH, 32, DRAM byte address width.
- DATA_WIDTH, 32, DRAM word width.
- LEN_WIDTH, 12, burst length field width, in beats.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester burst request; level, held until gnt.
- req_we  in  N_REQ  1 = write burst, 0 = read burst.
- req_addr  in  N_REQ*ADDR_WIDTH  burst byte base address; word aligned.
- req_len  in  N_REQ*LEN_WIDTH  beats in the burst.
- req_wdata  in  N_REQ*DATA_WIDTH  current write word of each requester.
- gnt  out  N_REQ  one-cycle pulse: burst accepted; owner deasserts or re-arms req.
- beat_ready  out  N_REQ  beat issued this cycle; writer advances req_wdata next cycle.
- rvalid  out  N_REQ  read word valid for that requester.
- rdata  out  DATA_WIDTH  read word; direct pass-through of dram_r_data.
- dram_we  out  1  DRAM write enable.
- dram_addr  out  ADDR_WIDTH  DRAM byte address.
- dram_w_data  out  DATA_WIDTH  DRAM write word.
- dram_r_data  in  DATA_WIDTH  DRAM read word, valid the cycle after the address is sampled.
- perf_busy_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0): asserts immediately, no clock needed.
  - Clears to 0: gnt, beat_ready, rvalid, dram_we, dram_addr, dram_w_data, perf_busy_cycles, beat counter and read pipeline.
  - FSM goes to IDLE; round-robin pointer goes to N_REQ-1, so requester 0 wins first.
  - A burst in flight is abandoned; requesters re-request after reset.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req is set, pick the first requester searching upward from pointer+1, modulo N_REQ.
  - Pulse gnt[winner] for one cycle.
  - Latch owner, base, len and we; set beat=0; pointer := winner.
  - If len==0: no DRAM access, stay IDLE. Otherwise go to BURST next cycle.
  - The arbitration cycle issues no beat.
- BURST, each cycle:
  - beat_ready[owner]=1 (combinational).
  - Registered at the edge: dram_addr <= base + 4*beat (modulo 2^ADDR_WIDTH), dram_we <= we, dram_w_data <= req_wdata[owner] when we, else held.
  - beat++. When beat == len-1, go to IDLE.
  - dram_we drops to 0 in the cycle after the last write beat.
- Read timing:
  - Beat issued at cycle k; dram_addr is valid in cycle k+1; dram_r_data is valid in cycle k+2.
  - rvalid[owner] is high in cycle k+2, driven by a 2-stage valid/owner pipeline that is independent of the FSM.
  - Latency beat_ready -> rvalid is exactly 2 cycles; one rvalid per beat, in order.
- Throughput and fairness:
  - Back-to-back bursts: 1 idle arbitration cycle between them.
  - A new burst's first dram_addr can coincide with the previous burst's last rvalid; no conflict, because rvalid is tagged by the pipelined owner.
  - req changes during BURST are ignored until IDLE.
  - Simultaneous requests are resolved by round-robin only, so there is no starvation.
- At most one bit of gnt, beat_ready and rvalid is set at any time.
- rdata is undefined whenever no rvalid bit is set.

Optional Feature:
- Macro: DRAM_ARB_PERF_EN.
- Defined: perf_busy_cycles counts the cycles in BURST. It saturates at 0xFFFFFFFF and is cleared by reset only.
- Undefined: perf_busy_cycles is tied to 0 and no counter is synthesized.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - requester index constants REQ_IFMAP=0, REQ_FILTER=1, REQ_BIAS=2, REQ_OPSUM=3;
  - the byte stride constant WORD_BYTES=4.
- Sub-module rr_arbiter: pure combinational round-robin pick of (req, pointer) -> one-hot winner. It is reused by the GLB bank arbiter.

Test Plan:
- Single read, requester 0, addr 0, len 3, DRAM preloaded with 0x04030201, 0x08070605, 0x0C0B0A09 -> gnt[0] one cycle; dram_addr 0, 4, 8 on consecutive cycles; rvalid[0] for 3 cycles carrying those words, first one 2 cycles after the first beat_ready.
- Write burst, requester 3, addr 7400, len 4, req_wdata stepping 1, 2, 3, 4 on beat_ready -> DRAM bytes 7400..7415 hold words 1..4; dram_we high for exactly 4 cycles.
- All four req raised together, each len 2 -> grant order 0, 1, 2, 3; 3 idle cycles total between the bursts; no overlap of dram_addr ownership.
- Requester 1 re-requests after gnt while requester 2 waits -> requester 2 is granted before requester 1's second burst.
- len=0 request from requester 2 -> gnt[2] pulse; no dram_we, no rvalid, FSM stays IDLE.
- rst driven low in the middle of the 2nd beat of an 8-beat write -> dram_we=0 immediately with no clock edge; all outputs 0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and constants for the DRAM port arbiter
//
// Purpose: FSM state encoding, requester index map and DRAM word stride used
// by dram_port_arbiter and its testbench.
// Ports: none (package).

package dram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Requester slots on the shared DRAM port.
  localparam int REQ_IFMAP  = 0;
  localparam int REQ_FILTER = 1;
  localparam int REQ_BIAS   = 2;
  localparam int REQ_OPSUM  = 3;

  // Byte distance between consecutive 32-bit beats.
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dram_port_arbiter_rr_arbiter.sv
// rtl/dram_port_arbiter_rr_arbiter.sv - combinational round-robin pick
//
// Purpose: given the request vector and the index of the last winner, returns
// the first requester found searching upward from ptr+1 (wrapping at N).
// Shared with the GLB bank arbiter, so it holds no state of its own.
// Ports:
//   req        in  N      request levels
//   ptr        in  IDX_W  index of the previous winner
//   grant      out N      one-hot winner (all zero when no request)
//   grant_idx  out IDX_W  binary index of the winner
//   any        out 1      at least one request is present

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int idx;

  // Walk N positions starting just after ptr; the wrap to ptr itself comes
  // last, so the previous winner only wins again when nobody else asks.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[IDX_W'(idx)]) begin
        any                = 1'b1;
        grant[IDX_W'(idx)] = 1'b1;
        grant_idx          = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin burst arbiter for the shared DLA DRAM port
//
// Purpose: shares one word-wide DRAM port between the ifmap, filter and bias
// loaders and the opsum writer. A granted burst owns the port until its last
// beat; the next owner is chosen round-robin after one arbitration cycle.
// Optional macro: DRAM_ARB_PERF_EN enables the saturating BURST-cycle counter
// on perf_busy_cycles; otherwise that output is tied to zero.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req/req_we        per-requester burst request level and direction
//   req_addr/req_len  per-requester byte base address and beat count
//   req_wdata         per-requester current write word
//   gnt               one-cycle burst-accepted pulse
//   beat_ready        beat issued this cycle (writer advances next cycle)
//   rvalid/rdata      read return, tagged to the owner that issued the beat
//   dram_*            registered DRAM pins; dram_r_data is the read return
//   perf_busy_cycles  BURST cycle count (macro-enabled)

module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            beat_ready,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        dram_we,
  output logic [ADDR_WIDTH-1:0]       dram_addr,
  output logic [DATA_WIDTH-1:0]       dram_w_data,
  input  logic [DATA_WIDTH-1:0]       dram_r_data,
  output logic [31:0]                 perf_busy_cycles
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e state, state_nxt;

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      win_idx;
  logic [N_REQ-1:0]      win;
  logic                  win_any;

  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  beat;
  logic                  we;
  logic                  last_beat;

  // First stage of the read-return tag pipeline; rvalid is the second stage.
  logic                  s1_valid;
  logic [IDX_W-1:0]      s1_owner;

  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [LEN_WIDTH-1:0]  len_arr   [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]   = req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (win),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign last_beat = (beat == len - 1'b1);
  assign rdata     = dram_r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // gnt is combinational so a zero-length burst can be acknowledged and
  // dropped in the same IDLE cycle without being granted twice.
  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    beat_ready = '0;
    case (state)
      IDLE: begin
        if (win_any) begin
          gnt = win;
          if (len_arr[win_idx] != '0) begin
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        beat_ready[owner] = 1'b1;
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= IDX_W'(N_REQ - 1);
      owner       <= '0;
      base        <= '0;
      len         <= '0;
      beat        <= '0;
      we          <= 1'b0;
      dram_we     <= 1'b0;
      dram_addr   <= '0;
      dram_w_data <= '0;
      s1_valid    <= 1'b0;
      s1_owner    <= '0;
      rvalid      <= '0;
    end else begin
      case (state)
        IDLE: begin
          dram_we <= 1'b0;
          if (win_any) begin
            owner <= win_idx;
            ptr   <= win_idx;
            base  <= addr_arr[win_idx];
            len   <= len_arr[win_idx];
            we    <= req_we[win_idx];
            beat  <= '0;
          end
        end
        BURST: begin
          dram_addr <= base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(WORD_BYTES);
          dram_we   <= we;
          if (we) begin
            dram_w_data <= wdata_arr[owner];
          end
          beat <= beat + 1'b1;
        end
        default: dram_we <= 1'b0;
      endcase

      // The tag travels with the beat, so a read return from the previous
      // burst is still credited correctly while the next burst starts.
      s1_valid <= (state == BURST) && !we;
      s1_owner <= owner;
      rvalid   <= s1_valid ? (N_REQ'(1) << s1_owner) : '0;
    end
  end

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] busy_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
    end else if (state == BURST && busy_cnt != 32'hFFFF_FFFF) begin
      busy_cnt <= busy_cnt + 32'd1;
    end
  end

  assign perf_busy_cycles = busy_cnt;
`else
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter

module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req, req_we;
  logic [127:0] req_addr, req_wdata;
  logic [47:0]  req_len;
  logic [3:0]   gnt, beat_ready, rvalid;
  logic [31:0]  rdata, dram_addr, dram_w_data, dram_r_data, perf_busy_cycles;
  logic         dram_we;

  dram_port_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ready(beat_ready),
    .rvalid(rvalid), .rdata(rdata), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_w_data(dram_w_data), .dram_r_data(dram_r_data),
    .perf_busy_cycles(perf_busy_cycles)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    int          len;
    logic [31:0] wbase;
    int          exp_we;
    int          exp_rv;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [0:4095];
  logic        cfg_we    [4];
  logic [31:0] cfg_addr  [4];
  int          cfg_len   [4];
  logic [31:0] cfg_wbase [4];
  int          armed     [4];
  int          granted   [4];
  int          wcnt      [4];
  logic [3:0]  br_s, gnt_s, prev_br;
  beat_t       q[$];
  beat_t       rv_pend;
  logic        rv_pend_valid;
  int          glog[$];
  int          gcyc[$];
  int          cyc, we_cnt, rv_cnt, busy_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int id);
    oh = 4'b0001 << id;
  endfunction

  // DRAM: registered read, data one cycle after the address is sampled.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h0403_0201;
    mem[1] = 32'h0807_0605;
    mem[2] = 32'h0C0B_0A09;
    dram_r_data = '0;
    forever begin
      @(posedge clk);
      if (dram_we) mem[dram_addr[13:2]] = dram_w_data;
      dram_r_data <= mem[dram_addr[13:2]];
    end
  end

  // Requesters: hold req while armed bursts remain, step write data after each beat.
  initial begin
    req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin granted[i] = 0; wcnt[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!rst) granted[i] = armed[i];
        else begin
          if (br_s[i]) wcnt[i]++;
          if (gnt_s[i]) granted[i]++;
        end
        req[i]                = (armed[i] > granted[i]);
        req_we[i]             = cfg_we[i];
        req_addr[i*32 +: 32]  = cfg_addr[i];
        req_len[i*12 +: 12]   = 12'(cfg_len[i]);
        req_wdata[i*32 +: 32] = cfg_wbase[i] + 32'(wcnt[i]);
      end
    end
  end

  // Scoreboard: beats queued at grant, popped when the registered beat appears.
  initial begin
    beat_t       e;
    logic [3:0]  exp_rv;
    logic [31:0] a;
    int          id;
    br_s = '0; gnt_s = '0; prev_br = '0; rv_pend_valid = 1'b0;
    cyc = 0; we_cnt = 0; rv_cnt = 0; busy_model = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        q.delete(); prev_br = '0; rv_pend_valid = 1'b0;
        br_s = '0; gnt_s = '0; busy_model = 0;
      end else begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("beat_ready_onehot0", 32'($onehot0(beat_ready)), 32'd1);
        exp_rv = rv_pend_valid ? oh(rv_pend.id) : 4'b0000;
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        if (rv_pend_valid) begin
          check("rdata", rdata, rv_pend.rdata);
          rv_cnt++;
        end
        rv_pend_valid = 1'b0;
        if (prev_br != 4'b0000) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: actual=%b expected=none", prev_br);
          end else begin
            e = q.pop_front();
            check("beat_owner", 32'(prev_br), 32'(oh(e.id)));
            check("dram_addr", dram_addr, e.addr);
            check("dram_we", 32'(dram_we), 32'(e.we));
            if (e.we) check("dram_w_data", dram_w_data, e.wdata);
            else begin rv_pend = e; rv_pend_valid = 1'b1; end
          end
        end else begin
          check("dram_we_idle", 32'(dram_we), 32'd0);
        end
        if (dram_we) we_cnt++;
        if (beat_ready != 4'b0000) busy_model++;
        if (gnt != 4'b0000) begin
          id = 0;
          for (int i = 0; i < 4; i++) if (gnt[i]) id = i;
          glog.push_back(id);
          gcyc.push_back(cyc);
          for (int b = 0; b < cfg_len[id]; b++) begin
            a       = cfg_addr[id] + 32'(4 * b);
            e.id    = id;
            e.we    = cfg_we[id];
            e.addr  = a;
            e.wdata = cfg_wbase[id] + 32'(wcnt[id] + b);
            e.rdata = mem[a[13:2]];
            q.push_back(e);
          end
        end
        prev_br = beat_ready; br_s = beat_ready; gnt_s = gnt;
      end
    end
  end

  function automatic logic drained(input int n_gnt);
    drained = (glog.size() >= n_gnt) && (q.size() == 0) && !rv_pend_valid && (prev_br == 4'b0000);
  endfunction

  task automatic wait_done(input int n_gnt, input int budget);
    int k;
    k = 0;
    while (!drained(n_gnt) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (!drained(n_gnt)) begin
      tests++; fails++;
      $display("FAIL wait_done: actual=%0d grants expected=%0d within %0d cycles", glog.size(), n_gnt, budget);
    end
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic check_order(input string name, input int exp_ids[$]);
    check({name, "_count"}, 32'(glog.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < glog.size(); i++)
      check(name, 32'(glog[i]), 32'(exp_ids[i]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_beat_ready"}, 32'(beat_ready), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_dram_we"}, 32'(dram_we), 32'd0);
    check({tag, "_dram_addr"}, dram_addr, 32'd0);
    check({tag, "_dram_w_data"}, dram_w_data, 32'd0);
    check({tag, "_perf"}, perf_busy_cycles, 32'd0);
  endtask

  task automatic set_cfg(input int id, input logic w, input logic [31:0] a, input int l, input logic [31:0] wb);
    cfg_we[id] = w; cfg_addr[id] = a; cfg_len[id] = l; cfg_wbase[id] = wb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   k;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin armed[i] = 0; set_cfg(i, 1'b0, 32'd0, 0, 32'd0); end
    vecs[0] = '{REQ_IFMAP,  1'b0, 32'd0,          3, 32'd0,     0, 3};
    vecs[1] = '{REQ_OPSUM,  1'b1, 32'd7400,       4, 32'd1,     4, 0};
    vecs[2] = '{REQ_FILTER, 1'b0, 32'd7400,       4, 32'd0,     0, 4};
    vecs[3] = '{REQ_BIAS,   1'b0, 32'hFFFF_FFF8,  3, 32'd0,     0, 3};
    vecs[4] = '{REQ_BIAS,   1'b1, 32'd16,         1, 32'h0000_00AA, 1, 0};
    vecs[5] = '{REQ_BIAS,   1'b0, 32'd0,          0, 32'd0,     0, 0};
    vecs[6] = '{REQ_IFMAP,  1'b0, 32'd16,         1, 32'd0,     0, 1};

    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    for (int t = 0; t < 7; t++) begin
      v = vecs[t];
      @(negedge clk); #1;
      set_cfg(v.id, v.we, v.addr, v.len, v.wbase);
      glog.delete(); gcyc.delete(); we_cnt = 0; rv_cnt = 0;
      armed[v.id]++;
      wait_done(1, 60);
      check("vec_gnt_count", 32'(glog.size()), 32'd1);
      if (glog.size() > 0) check("vec_gnt_id", 32'(glog[0]), 32'(v.id));
      check("vec_we_cycles", 32'(we_cnt), 32'(v.exp_we));
      check("vec_rvalid_cycles", 32'(rv_cnt), 32'(v.exp_rv));
    end
    for (int b = 0; b < 4; b++) check("wr_mem_7400", mem[1850 + b], 32'(b + 1));
    check("wr_mem_16", mem[4], 32'h0000_00AD);

    // Reset in the middle of the second beat of an 8-beat write.
    @(negedge clk); #1;
    set_cfg(REQ_FILTER, 1'b1, 32'd256, 8, 32'd100);
    glog.delete();
    armed[REQ_FILTER]++;
    k = 0;
    @(negedge clk);
    while (beat_ready[REQ_FILTER] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      tests++; fails++;
      $display("FAIL rst_mid_write_start: actual=no beat expected=beat within 50 cycles");
    end
    @(negedge clk);
    check("we_before_rst", 32'(dram_we), 32'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk); #1;
    set_cfg(REQ_IFMAP, 1'b0, 32'd0, 1, 32'd0);
    set_cfg(REQ_BIAS,  1'b0, 32'd4, 1, 32'd0);
    set_cfg(REQ_OPSUM, 1'b0, 32'd8, 1, 32'd0);
    glog.delete();
    armed[REQ_IFMAP]++; armed[REQ_BIAS]++; armed[REQ_OPSUM]++;
    wait_done(3, 80);
    check_order("post_rst_order", '{0, 2, 3});

    // All four at once: strict rotation with one arbitration cycle per burst.
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) set_cfg(i, 1'b0, 32'(i * 64), 2, 32'd0);
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 4; i++) armed[i]++;
    wait_done(4, 100);
    check_order("all4_order", '{0, 1, 2, 3});
    for (int i = 1; i < 4 && i < gcyc.size(); i++)
      check("all4_gnt_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);

    // Requester 1 keeps asking; requester 2 must get in between.
    @(negedge clk); #1;
    set_cfg(REQ_FILTER, 1'b0, 32'd512, 2, 32'd0);
    set_cfg(REQ_BIAS,   1'b0, 32'd600, 2, 32'd0);
    glog.delete();
    armed[REQ_FILTER] += 2; armed[REQ_BIAS]++;
    wait_done(3, 100);
    check_order("fair_order", '{1, 2, 1});

`ifdef DRAM_ARB_PERF_EN
    check("perf_busy_cycles", perf_busy_cycles, 32'(busy_model));
`else
    check("perf_busy_cycles", perf_busy_cycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
